gate_exerciser: RTL and testbench
=================================

// Module: gate_exerciser
// PURPOSE
//  Sequential stimulus/check engine for the combinational gate labs.
//  Drives every input pattern into an external N_IN-input gate and samples its
//  1-bit response after a settle delay. Compares each response with a reference
//  truth table selected by OP_SEL, then reports pass/fail and an error count.
//  Sits on the board top between the switch/button front end and the gate under test.
// PARAMETERS
//  N_IN        2   gate input width; the engine walks 2**N_IN patterns
//  SETTLE_CYC  2   cycles PAT_OUT is held before DUT_IN is sampled; legal range >= 1
// PORTS
//  CLK        in   1        system clock, rising edge
//  RST        in   1        synchronous, active-high reset
//  START      in   1        run request; sampled only in IDLE
//  OP_SEL     in   2        expected function: 0 AND, 1 OR, 2 XOR, 3 NAND
//  DUT_IN     in   1        response from the gate under test
//  PAT_OUT    out  N_IN     pattern driven to the gate inputs
//  BUSY       out  1        high while a run is in progress
//  DONE       out  1        one-cycle pulse at end of run
//  PASS       out  1        1 when the last run had zero mismatches
//  ERR_CNT    out  N_IN+1   mismatch count of the last or current run
// BEHAVIOUR
//  Reset: all outputs 0, FSM in IDLE, settle counter 0.
//  FSM states: IDLE -> DRIVE -> SAMPLE -> (DRIVE | FINISH) -> IDLE.
//  IDLE: START=1 at edge t. At t+1: BUSY=1, PAT_OUT=0, ERR_CNT=0, PASS=0, OP_SEL latched.
//  DRIVE: hold PAT_OUT for SETTLE_CYC cycles, then go to SAMPLE.
//  SAMPLE (1 cycle): mismatch = DUT_IN != ref(op, PAT_OUT); ERR_CNT += mismatch.
//    If PAT_OUT is not all-ones: increment PAT_OUT and return to DRIVE.
//    Otherwise: PAT_OUT wraps to 0 and the FSM goes to FINISH.
//  Each vector takes SETTLE_CYC+1 cycles. BUSY is high for 2**N_IN*(SETTLE_CYC+1) cycles.
//  FINISH (1 cycle): BUSY=0, DONE=1, PASS=(ERR_CNT==0); then IDLE.
//  PASS and ERR_CNT hold until the next accepted START.
//  ERR_CNT cannot overflow: its width holds up to 2**N_IN.
//  START during DRIVE, SAMPLE or FINISH is ignored. OP_SEL changes mid-run are ignored.
//  RST at any cycle, including mid-run, forces reset values at the next edge;
//    a run in progress is abandoned and DONE does not pulse.
//  DUT_IN is assumed synchronous to CLK (the gate is driven from PAT_OUT registers).
// CONFIGURATION
//  GATE_EXER_FAIL_LOG_EN defined:
//    Adds outputs FAIL_VALID (1 bit) and FAIL_VEC (N_IN bits).
//    The first mismatch of a run captures PAT_OUT into FAIL_VEC and sets FAIL_VALID.
//    Later mismatches leave both unchanged.
//    Both clear on reset and on an accepted START.
//  GATE_EXER_FAIL_LOG_EN undefined: these ports and registers do not exist;
//    all other behaviour is identical.
// STRUCTURE
//  Package gate_exer_pkg:
//    OP_AND/OP_OR/OP_XOR/OP_NAND encodings (2'd0..2'd3).
//    FSM state encodings ST_IDLE/ST_DRIVE/ST_SAMPLE/ST_FINISH.
//  Sub-module gate_ref_model: combinational (op, N_IN-bit pattern) -> expected bit,
//    computed as a reduction over all N_IN bits.
//  Top level holds the FSM, settle counter, pattern counter, error counter and optional fail log.
// TESTING (N_IN=2, SETTLE_CYC=2, 12 BUSY cycles per run)
//  1 RST=1 for 2 cycles with START=1 -> BUSY/DONE/PASS/ERR_CNT/PAT_OUT stay 0.
//  2 OP_SEL=0, DUT_IN=&PAT_OUT -> PAT_OUT walks 0,1,2,3 (3 cycles each), BUSY 12 cycles,
//    then DONE=1 for 1 cycle, PASS=1, ERR_CNT=0.
//  3 OP_SEL=1, DUT_IN=&PAT_OUT -> ERR_CNT=2, PASS=0, FAIL_VEC=2'b01 with FAIL_VALID=1 (log enabled).
//  4 OP_SEL=3, DUT_IN tied 1 -> ERR_CNT=1, PASS=0, FAIL_VEC=2'b11.
//  5 Case 2 with START re-pulsed and OP_SEL=2 at busy cycle 4 -> result identical to case 2.
//  6 RST pulsed at busy cycle 5 -> next cycle BUSY=0, PAT_OUT=0, no DONE;
//    a fresh START then completes a full 12-cycle run.

Source files
------------

// File: rtl/gate_exer_pkg.sv
// gate_exer_pkg: op and FSM state encodings shared by the gate exerciser
package gate_exer_pkg;
  typedef enum logic [1:0] {OP_AND = 2'd0, OP_OR = 2'd1, OP_XOR = 2'd2, OP_NAND = 2'd3} op_e;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_DRIVE = 2'd1, ST_SAMPLE = 2'd2, ST_FINISH = 2'd3} state_e;
endpackage

// File: rtl/gate_ref_model.sv
// gate_ref_model: expected gate output for an op over all pattern bits
module gate_ref_model
  import gate_exer_pkg::*;
#(
  parameter int N_IN = 2
) (
  input  op_e             op_i,
  input  logic [N_IN-1:0] pat_i,
  output logic            exp_o
);
  always_comb
    exp_o = op_i == OP_AND ? &pat_i :
            op_i == OP_OR  ? |pat_i :
            op_i == OP_XOR ? ^pat_i : ~&pat_i;
endmodule

// File: rtl/gate_exerciser.sv
// gate_exerciser: walks all patterns into an external gate and counts mismatches; GATE_EXER_FAIL_LOG_EN adds a first-fail log
module gate_exerciser
  import gate_exer_pkg::*;
#(
  parameter int N_IN       = 2,
  parameter int SETTLE_CYC = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [1:0]      op_sel_i,
  input  logic            dut_in_i,
  output logic [N_IN-1:0] pat_out_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            pass_o,
  output logic [N_IN:0]   err_cnt_o
`ifdef GATE_EXER_FAIL_LOG_EN
  ,
  output logic            fail_valid_o,
  output logic [N_IN-1:0] fail_vec_o
`endif
);
  localparam int CW = SETTLE_CYC > 1 ? $clog2(SETTLE_CYC) : 1;
  state_e          state_q;
  op_e             op_q;
  logic [CW-1:0]   cnt_q;
  logic [N_IN-1:0] pat_q;
  logic [N_IN:0]   err_q, err_d;
  logic            busy_q, done_q, pass_q, exp_bit, mismatch;
  gate_ref_model #(.N_IN(N_IN)) u_ref (.op_i(op_q), .pat_i(pat_q), .exp_o(exp_bit));
  always_comb begin
    mismatch = dut_in_i != exp_bit;
    err_d    = err_q + (N_IN+1)'(mismatch);
  end
`ifdef GATE_EXER_FAIL_LOG_EN
  logic            fail_valid_q;
  logic [N_IN-1:0] fail_vec_q;
  always_ff @(posedge clk_i)
    if (rst_i || (state_q == ST_IDLE && start_i)) begin
      fail_valid_q <= 1'b0;
      fail_vec_q   <= '0;
    end else if (state_q == ST_SAMPLE && mismatch && !fail_valid_q) begin
      fail_valid_q <= 1'b1;
      fail_vec_q   <= pat_q;
    end
  assign fail_valid_o = fail_valid_q;
  assign fail_vec_o   = fail_vec_q;
`endif
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      op_q    <= OP_AND;
      cnt_q   <= '0;
      pat_q   <= '0;
      err_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE:
          if (start_i) begin
            state_q <= ST_DRIVE;
            op_q    <= op_e'(op_sel_i);
            cnt_q   <= '0;
            pat_q   <= '0;
            err_q   <= '0;
            busy_q  <= 1'b1;
            pass_q  <= 1'b0;
          end
        ST_DRIVE: begin
          cnt_q   <= cnt_q == CW'(SETTLE_CYC - 1) ? '0 : cnt_q + CW'(1);
          state_q <= cnt_q == CW'(SETTLE_CYC - 1) ? ST_SAMPLE : ST_DRIVE;
        end
        ST_SAMPLE: begin
          err_q   <= err_d;
          pat_q   <= pat_q + N_IN'(1);
          state_q <= &pat_q ? ST_FINISH : ST_DRIVE;
          if (&pat_q) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            pass_q <= err_d == '0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
  assign pat_out_o = pat_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign pass_o    = pass_q;
  assign err_cnt_o = err_q;
endmodule

// File: tb/tb_gate_exerciser.sv
// tb_gate_exerciser: directed checks of the gate exerciser with N_IN=2, SETTLE_CYC=2
module tb_gate_exerciser;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [1:0] op_sel = 2'd0;
  logic       tie_one = 1'b0;
  logic       dut_in;
  logic [1:0] pat_out_o;
  logic       busy_o, done_o, pass_o;
  logic [2:0] err_cnt_o;
`ifdef GATE_EXER_FAIL_LOG_EN
  logic       fail_valid_o;
  logic [1:0] fail_vec_o;
`endif
  int n_chk = 0;
  int n_fail = 0;
  int nbusy, ndone;
  logic [1:0] pat_log [0:15];
  always #5 clk = ~clk;
  assign dut_in = tie_one ? 1'b1 : &pat_out_o;
  gate_exerciser #(.N_IN(2), .SETTLE_CYC(2)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .op_sel_i(op_sel), .dut_in_i(dut_in),
    .pat_out_o(pat_out_o), .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .err_cnt_o(err_cnt_o)
`ifdef GATE_EXER_FAIL_LOG_EN
    , .fail_valid_o(fail_valid_o), .fail_vec_o(fail_vec_o)
`endif
  );
  task automatic run(input logic [1:0] op, input int glitch);
    nbusy = 0;
    ndone = 0;
    @(negedge clk);
    op_sel = op;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (busy_o === 1'b1) begin
        if (nbusy < 16) pat_log[nbusy] = pat_out_o;
        nbusy++;
      end
      if (done_o === 1'b1) ndone++;
      if (i == glitch) begin
        start = 1'b1;
        op_sel = 2'd2;
      end else start = 1'b0;
      @(negedge clk);
    end
  endtask
  task automatic test_reset;
    rst = 1'b1;
    start = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_chk++;
      if ({busy_o, done_o, pass_o, err_cnt_o, pat_out_o} !== 8'd0) begin
        n_fail++;
        $display("FAIL reset_c%0d: got busy=%b done=%b pass=%b err=%0d pat=%0d expected all 0", c, busy_o, done_o, pass_o, err_cnt_o, pat_out_o);
      end
    end
    rst = 1'b0;
    start = 1'b0;
  endtask
  task automatic test_and_pass;
    tie_one = 1'b0;
    run(2'd0, -1);
    n_chk++;
    if (nbusy != 12) begin n_fail++; $display("FAIL and_busy_len: got %0d expected 12", nbusy); end
    n_chk++;
    if (ndone != 1) begin n_fail++; $display("FAIL and_done_cnt: got %0d expected 1", ndone); end
    for (int k = 0; k < 12; k++) begin
      n_chk++;
      if (pat_log[k] !== 2'(k / 3)) begin n_fail++; $display("FAIL and_pat_%0d: got %0d expected %0d", k, pat_log[k], k / 3); end
    end
    n_chk++;
    if (pass_o !== 1'b1 || err_cnt_o !== 3'd0) begin n_fail++; $display("FAIL and_result: got pass=%b err=%0d expected pass=1 err=0", pass_o, err_cnt_o); end
  endtask
  task automatic test_or_fail;
    tie_one = 1'b0;
    run(2'd1, -1);
    n_chk++;
    if (pass_o !== 1'b0 || err_cnt_o !== 3'd2) begin n_fail++; $display("FAIL or_result: got pass=%b err=%0d expected pass=0 err=2", pass_o, err_cnt_o); end
    n_chk++;
    if (ndone != 1) begin n_fail++; $display("FAIL or_done_cnt: got %0d expected 1", ndone); end
`ifdef GATE_EXER_FAIL_LOG_EN
    n_chk++;
    if (fail_valid_o !== 1'b1 || fail_vec_o !== 2'b01) begin n_fail++; $display("FAIL or_faillog: got valid=%b vec=%b expected valid=1 vec=01", fail_valid_o, fail_vec_o); end
`endif
  endtask
  task automatic test_nand_fail;
    tie_one = 1'b1;
    run(2'd3, -1);
    tie_one = 1'b0;
    n_chk++;
    if (pass_o !== 1'b0 || err_cnt_o !== 3'd1) begin n_fail++; $display("FAIL nand_result: got pass=%b err=%0d expected pass=0 err=1", pass_o, err_cnt_o); end
`ifdef GATE_EXER_FAIL_LOG_EN
    n_chk++;
    if (fail_valid_o !== 1'b1 || fail_vec_o !== 2'b11) begin n_fail++; $display("FAIL nand_faillog: got valid=%b vec=%b expected valid=1 vec=11", fail_valid_o, fail_vec_o); end
`endif
  endtask
  task automatic test_start_ignored;
    tie_one = 1'b0;
    run(2'd0, 4);
    n_chk++;
    if (nbusy != 12) begin n_fail++; $display("FAIL restart_busy_len: got %0d expected 12", nbusy); end
    n_chk++;
    if (ndone != 1) begin n_fail++; $display("FAIL restart_done_cnt: got %0d expected 1", ndone); end
    n_chk++;
    if (pass_o !== 1'b1 || err_cnt_o !== 3'd0) begin n_fail++; $display("FAIL restart_result: got pass=%b err=%0d expected pass=1 err=0", pass_o, err_cnt_o); end
  endtask
  task automatic test_mid_reset;
    int d = 0;
    int b = 0;
    tie_one = 1'b1;
    @(negedge clk);
    op_sel = 2'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_chk++;
    if ({busy_o, done_o, err_cnt_o, pat_out_o} !== 7'd0) begin n_fail++; $display("FAIL midrst_state: got busy=%b done=%b err=%0d pat=%0d expected all 0", busy_o, done_o, err_cnt_o, pat_out_o); end
    for (int i = 0; i < 15; i++) begin
      if (done_o === 1'b1) d++;
      if (busy_o === 1'b1) b++;
      @(negedge clk);
    end
    n_chk++;
    if (d != 0 || b != 0) begin n_fail++; $display("FAIL midrst_quiet: got done=%0d busy=%0d expected 0 0", d, b); end
    tie_one = 1'b0;
    run(2'd0, -1);
    n_chk++;
    if (nbusy != 12 || ndone != 1) begin n_fail++; $display("FAIL midrst_rerun: got busy=%0d done=%0d expected 12 1", nbusy, ndone); end
    n_chk++;
    if (pass_o !== 1'b1 || err_cnt_o !== 3'd0) begin n_fail++; $display("FAIL midrst_result: got pass=%b err=%0d expected pass=1 err=0", pass_o, err_cnt_o); end
  endtask
  initial begin
    test_reset;
    test_and_pass;
    test_or_fail;
    test_nand_fail;
    test_start_ignored;
    test_mid_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
